// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller between a core load/store port and a
// single-cycle-latency RAM.
//
// Ports:
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   req_i / gnt_o               core request / request accepted this cycle
//   addr_i, we_i, size_i        byte address, store flag, size (00 B, 01 H, 10 W)
//   sign_ext_i, wdata_i         load sign-extension, right-aligned store data
//   rvalid_o / rready_i         response valid / core accepts the response
//   rdata_o, err_o              aligned+extended load data, error flag
//   ram_en_o, ram_we_o          RAM enable / write enable
//   ram_addr_o, ram_be_o        RAM byte address / byte enables
//   ram_wdata_o, ram_rdata_i    RAM write data / read data (valid one cycle later)
module dmem_ctrl #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic [31:0]           addr_i,
    input  logic                  we_i,
    input  logic [1:0]            size_i,
    input  logic                  sign_ext_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o,
    output logic                  ram_en_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic                  ram_we_o,
    output logic [3:0]            ram_be_o,
    output logic [DATA_WIDTH-1:0] ram_wdata_o,
    input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

    typedef enum logic [1:0] {IDLE, RESP, HOLD} state_t;

    // Address bits above the RAM range must be zero.
    localparam logic [31:0] HI_MASK = ~((32'd1 << ADDR_WIDTH) - 32'd1);

    state_t      state_q, state_d;
    logic        gnt;
    logic        req_err;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        sext_q;
    logic        we_q;
    logic        err_q;
    logic [31:0] hold_data_q;
    logic        hold_err_q;
    logic [31:0] lane;
    logic [31:0] resp_data;

    always_comb begin
        req_err = 1'b0;
        unique case (size_i)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = addr_i[0];
            2'b10:   req_err = |addr_i[1:0];
            default: req_err = 1'b1;
        endcase
        if (|(addr_i & HI_MASK)) req_err = 1'b1;
    end

    always_comb begin
        gnt = 1'b0;
        unique case (state_q)
            IDLE:    gnt = req_i;
            RESP:    gnt = req_i & rready_i;
            default: gnt = 1'b0;
        endcase
    end

    // Reset is asynchronous, so outputs derived from inputs are gated too.
    assign gnt_o      = gnt & rst_ni;
    assign ram_en_o   = gnt_o & ~req_err;
    assign ram_we_o   = ram_en_o & we_i;
    assign ram_addr_o = addr_i[ADDR_WIDTH-1:0];

    always_comb begin
        ram_be_o    = 4'b1111;
        ram_wdata_o = wdata_i;
        unique case (size_i)
            2'b00: begin
                ram_be_o    = 4'b0001 << addr_i[1:0];
                ram_wdata_o = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                ram_be_o    = 4'b0011 << addr_i[1:0];
                ram_wdata_o = {2{wdata_i[15:0]}};
            end
            default: begin
                ram_be_o    = 4'b1111;
                ram_wdata_o = wdata_i;
            end
        endcase
    end

    // Load formatting from the registered attributes of the granted access.
    always_comb begin
        lane      = ram_rdata_i >> {off_q, 3'b000};
        resp_data = ram_rdata_i;
        unique case (size_q)
            2'b00:   resp_data = sext_q ? {{24{lane[7]}}, lane[7:0]}
                                        : {24'h0, lane[7:0]};
            2'b01:   resp_data = sext_q ? {{16{lane[15]}}, lane[15:0]}
                                        : {16'h0, lane[15:0]};
            default: resp_data = ram_rdata_i;
        endcase
        if (we_q || err_q) resp_data = '0;
    end

    always_comb begin
        state_d  = state_q;
        rvalid_o = 1'b0;
        rdata_o  = '0;
        err_o    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (gnt) state_d = RESP;
            end
            RESP: begin
                rvalid_o = 1'b1;
                rdata_o  = resp_data;
                err_o    = err_q;
                if (rready_i) state_d = gnt ? RESP : IDLE;
                else          state_d = HOLD;
            end
            HOLD: begin
                rvalid_o = 1'b1;
                rdata_o  = hold_data_q;
                err_o    = hold_err_q;
                if (rready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            off_q       <= '0;
            size_q      <= '0;
            sext_q      <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            hold_data_q <= '0;
            hold_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (gnt) begin
                off_q  <= addr_i[1:0];
                size_q <= size_i;
                sext_q <= sign_ext_i;
                we_q   <= we_i;
                err_q  <= req_err;
            end
            // RAM data is only valid during RESP; a stalled response is frozen here.
            if (state_q == RESP && !rready_i) begin
                hold_data_q <= resp_data;
                hold_err_q  <= err_q;
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: scoreboard bench for dmem_ctrl with a behavioural RAM.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, gnt, we, sext, rvalid, rready, err;
    logic [31:0] addr, wdata, rdata;
    logic [1:0]  size;
    logic        ram_en, ram_we;
    logic [15:0] ram_addr;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata, ram_rdata;

    logic [31:0] mem [0:255];
    logic [32:0] exp_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .addr_i(addr),
        .we_i(we), .size_i(size), .sign_ext_i(sext), .wdata_i(wdata),
        .rvalid_o(rvalid), .rready_i(rready), .rdata_o(rdata), .err_o(err),
        .ram_en_o(ram_en), .ram_addr_o(ram_addr), .ram_we_o(ram_we),
        .ram_be_o(ram_be), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
    );

    // RAM: read data is valid only in the cycle after the read; otherwise junk.
    always @(posedge clk) begin
        if (ram_en && ram_we)
            for (int b = 0; b < 4; b++)
                if (ram_be[b]) mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
        if (ram_en && !ram_we) ram_rdata <= mem[ram_addr[9:2]];
        else                   ram_rdata <= $urandom;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: every accepted response is compared to the oldest expectation.
    always @(negedge clk) begin
        if (rvalid === 1'b1 && rready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rvalid: got rdata %h err %b with nothing expected at %0t",
                         rdata, err, $time);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check("resp_rdata", rdata, e[31:0]);
                check("resp_err", {31'h0, err}, {31'h0, e[32]});
            end
        end
    end

    // One granted request cycle; called at posedge+1, returns at the next posedge+1.
    task automatic cyc_req(input logic w, input logic [1:0] sz, input logic sx,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be_exp, input logic [31:0] wd_exp,
                           input logic [31:0] rd_exp, input logic er_exp);
        req = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = wd; rready = 1'b1;
        #1;
        check("gnt", {31'h0, gnt}, 32'h1);
        check("ram_en", {31'h0, ram_en}, {31'h0, ~er_exp});
        check("ram_we", {31'h0, ram_we}, {31'h0, w & ~er_exp});
        check("ram_be", {28'h0, ram_be}, {28'h0, be_exp});
        check("ram_wdata", ram_wdata, wd_exp);
        exp_q.push_back({er_exp, rd_exp});
        @(posedge clk); #1;
        check("rvalid_latency", {31'h0, rvalid}, 32'h1);
    endtask

    task automatic idle_cyc();
        req = 1'b0; rready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        rst_n = 1'b0; req = 1'b1; we = 1'b0; size = 2'b10; sext = 1'b0;
        addr = 32'h10; wdata = 32'h0; rready = 1'b1;
        #12;
        check("rst_gnt", {31'h0, gnt}, 32'h0);
        check("rst_ram_en", {31'h0, ram_en}, 32'h0);
        check("rst_rvalid", {31'h0, rvalid}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Word store then load
        cyc_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0);
        cyc_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 4'b1111, 32'h0, 32'hDEADBEEF, 1'b0);
        idle_cyc();

        // Errors: misaligned half, size 11, out-of-range address
        cyc_req(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 4'b0110, 32'h0, 32'h0, 1'b1);
        cyc_req(1'b1, 2'b11, 1'b0, 32'h10, 32'h12345678, 4'b1111, 32'h12345678, 32'h0, 1'b1);
        cyc_req(1'b1, 2'b10, 1'b0, 32'h0001_0010, 32'h55555555, 4'b1111, 32'h55555555, 32'h0, 1'b1);
        idle_cyc();

        // Backpressure: load 0x10 (memory unchanged by the errored stores)
        req = 1'b1; we = 1'b0; size = 2'b10; sext = 1'b0; addr = 32'h10; rready = 1'b0;
        #1;
        check("bp_gnt_idle", {31'h0, gnt}, 32'h1);
        exp_q.push_back({1'b0, 32'hDEADBEEF});
        @(posedge clk); #1;
        for (int c = 0; c < 3; c++) begin
            addr = 32'h14 + 32'(4 * c);
            #1;
            check("bp_rvalid", {31'h0, rvalid}, 32'h1);
            check("bp_gnt", {31'h0, gnt}, 32'h0);
            check("bp_ram_en", {31'h0, ram_en}, 32'h0);
            check("bp_rdata", rdata, 32'hDEADBEEF);
            check("bp_err", {31'h0, err}, 32'h0);
            @(posedge clk); #1;
        end
        req = 1'b0; rready = 1'b1;
        @(posedge clk); #1;
        check("bp_idle_rvalid", {31'h0, rvalid}, 32'h0);

        // Byte store and sub-word loads: word at 0x10 becomes 0x80ADBEEF
        cyc_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h00000080, 4'b1000, 32'h80808080, 32'h0, 1'b0);
        cyc_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 4'b1000, 32'h0, 32'hFFFFFF80, 1'b0);
        cyc_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 4'b1000, 32'h0, 32'h00000080, 1'b0);
        cyc_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 4'b0010, 32'h0, 32'hFFFFFFBE, 1'b0);
        cyc_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 4'b1100, 32'h0, 32'hFFFF80AD, 1'b0);
        cyc_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 4'b1100, 32'h0, 32'h000080AD, 1'b0);
        cyc_req(1'b1, 2'b01, 1'b0, 32'h10, 32'h0000CAFE, 4'b0011, 32'hCAFECAFE, 32'h0, 1'b0);
        cyc_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 4'b1111, 32'h0, 32'h80ADCAFE, 1'b0);
        idle_cyc();

        // Back-to-back stores then loads
        cyc_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h11111111, 4'b1111, 32'h11111111, 32'h0, 1'b0);
        cyc_req(1'b1, 2'b10, 1'b0, 32'h24, 32'h22222222, 4'b1111, 32'h22222222, 32'h0, 1'b0);
        cyc_req(1'b1, 2'b10, 1'b0, 32'h28, 32'h33333333, 4'b1111, 32'h33333333, 32'h0, 1'b0);
        cyc_req(1'b1, 2'b10, 1'b0, 32'h2C, 32'h44444444, 4'b1111, 32'h44444444, 32'h0, 1'b0);
        cyc_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 4'b1111, 32'h0, 32'h11111111, 1'b0);
        cyc_req(1'b0, 2'b10, 1'b0, 32'h24, 32'h0, 4'b1111, 32'h0, 32'h22222222, 1'b0);
        cyc_req(1'b0, 2'b10, 1'b0, 32'h28, 32'h0, 4'b1111, 32'h0, 32'h33333333, 1'b0);
        cyc_req(1'b0, 2'b10, 1'b0, 32'h2C, 32'h0, 4'b1111, 32'h0, 32'h44444444, 1'b0);
        idle_cyc();
        check("b2b_drained", {31'h0, rvalid}, 32'h0);

        // Reset while in RESP: the pending response is discarded
        req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h20; rready = 1'b0;
        #1;
        check("rst_resp_gnt", {31'h0, gnt}, 32'h1);
        @(posedge clk); #1;
        check("rst_resp_rvalid_before", {31'h0, rvalid}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_resp_rvalid", {31'h0, rvalid}, 32'h0);
        check("rst_resp_gnt_low", {31'h0, gnt}, 32'h0);
        check("rst_resp_ram_en", {31'h0, ram_en}, 32'h0);
        req = 1'b0; rready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("post_rst_rvalid", {31'h0, rvalid}, 32'h0);
        end

        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
